// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared definitions for the FFT output reorder stage: default
//             sizes, reorder state encoding, complex-sample type and the
//             bit-reversal helper used for address generation.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

    localparam int LGMAX_DEF = 12;
    localparam int WIDTH_DEF = 16;
    // Width of the bit-reversal helper; LGMAX must not exceed it.
    localparam int BR_W      = 16;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [2*WIDTH_DEF-1:0] cplx_t;

    // Reverse the low lg bits of value; bits at or above lg come out zero.
    function automatic logic [BR_W-1:0] bitrev(input logic [BR_W-1:0] value,
                                               input int lg);
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            if (i < lg) begin
                r = {r[BR_W-2:0], value[i]};
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitrev_lane_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bitrev_lane_ram
//  Purpose  : Storage for one input lane of the reorder stage. One write port
//             and two read ports whose outputs are registered and only update
//             when i_re is high, so they double as held output data.
//  Ports    : i_clk, i_reset_n        clock, async active-low reset
//             i_we, i_waddr, i_wdata  write port
//             i_re                    read strobe (both ports)
//             i_raddr_a/b             read addresses
//             o_rdata_a/b             registered read data (reset to 0)
//  Revision : 1.0  initial release
// ============================================================================
module bitrev_lane_ram #(
    parameter int LGMAX = 12,
    parameter int DW    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_we,
    input  logic [LGMAX-1:0] i_waddr,
    input  logic [DW-1:0]    i_wdata,
    input  logic             i_re,
    input  logic [LGMAX-1:0] i_raddr_a,
    input  logic [LGMAX-1:0] i_raddr_b,
    output logic [DW-1:0]    o_rdata_a,
    output logic [DW-1:0]    o_rdata_b
);

    logic [DW-1:0] r_mem [0:(1<<LGMAX)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata_a <= '0;
            o_rdata_b <= '0;
        end else if (i_re) begin
            o_rdata_a <= r_mem[i_raddr_a];
            o_rdata_b <= r_mem[i_raddr_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bitreverse_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : bitreverse_cfg
//  Purpose  : Runtime-sized ping-pong bit-reverse reorder stage. Takes two
//             bit-reversed samples per beat, emits the previous frame in
//             natural order two samples per beat, with frame-sync realignment
//             and a pass-through bypass mode.
//  Ports    : i_clk, i_reset_n     clock, async active-low reset
//             i_ce, i_sync         beat strobe, frame-start marker
//             i_in_0, i_in_1       bit-reversed positions 2t, 2t+1
//             i_cfg_load           latch i_lgsize / i_bypass and restart
//             o_out_0, o_out_1     natural samples 2m, 2m+1
//             o_valid, o_sync      output beat strobe, first-pair marker
//             o_err                sync misalignment pulse
//  Revision : 1.0  initial release
// ============================================================================
import fft_pkg::*;

module bitreverse_cfg #(
    parameter int LGMAX = LGMAX_DEF,
    parameter int LGMIN = 3,
    parameter int WIDTH = WIDTH_DEF,
    parameter int LW    = $clog2(LGMAX+1)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_ce,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_in_0,
    input  logic [2*WIDTH-1:0] i_in_1,
    input  logic               i_cfg_load,
    input  logic [LW-1:0]      i_lgsize,
    input  logic               i_bypass,
    output logic [2*WIDTH-1:0] o_out_0,
    output logic [2*WIDTH-1:0] o_out_1,
    output logic               o_valid,
    output logic               o_sync,
    output logic               o_err
);

    // Word index width inside one ping-pong half.
    localparam int c_WW = LGMAX - 1;

    state_t             r_state, w_state_nxt;
    logic [c_WW-1:0]    r_wcnt, w_wcnt_nxt;
    logic               r_wbank, w_wbank_nxt;
    logic [LW-1:0]      r_lg, w_lg_clamp;
    logic               r_bypass;

    logic               w_we, w_rd_en, w_byp_en;
    logic               w_valid_nxt, w_sync_nxt, w_err_nxt;
    logic [c_WW-1:0]    w_wword, w_last, w_quarter, w_rd_word;
    logic [BR_W-1:0]    w_rev;
    logic [LGMAX-1:0]   w_waddr, w_raddr_a, w_raddr_b;
    logic               w_sel;

    logic               r_sel, r_use_byp;
    logic [2*WIDTH-1:0] r_byp_0, r_byp_1;

    logic [2*WIDTH-1:0] w_wdata  [2];
    logic [2*WIDTH-1:0] w_rdata_a[2];
    logic [2*WIDTH-1:0] w_rdata_b[2];

    always_comb begin
        if (i_lgsize < LW'(LGMIN))      w_lg_clamp = LW'(LGMIN);
        else if (i_lgsize > LW'(LGMAX)) w_lg_clamp = LW'(LGMAX);
        else                            w_lg_clamp = i_lgsize;
    end

    // Last word of a frame is N/2-1; at L = LGMAX the shift overflows to
    // zero and the subtraction wraps to all ones, which is still correct.
    assign w_last    = (c_WW'(1) << (r_lg - LW'(1))) - c_WW'(1);
    assign w_quarter = c_WW'(1) << (r_lg - LW'(2));

    // x[2m] sits at input position j = rev(2m) < N/2, x[2m+1] at j + N/2.
    // Both share lane j[0] = bit L-2 of m; their words are j>>1 and j>>1 + N/4.
    assign w_rev     = bitrev(BR_W'({r_wcnt, 1'b0}), 32'(r_lg));
    assign w_rd_word = w_rev[c_WW:1];
    assign w_sel     = |(r_wcnt & w_quarter);
    assign w_raddr_a = {~r_wbank, w_rd_word};
    assign w_raddr_b = {~r_wbank, w_rd_word | w_quarter};
    assign w_waddr   = {r_wbank, w_wword};

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_wbank_nxt = r_wbank;
        w_we        = 1'b0;
        w_rd_en     = 1'b0;
        w_byp_en    = 1'b0;
        w_valid_nxt = 1'b0;
        w_sync_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_wword     = r_wcnt;
        if (i_cfg_load) begin
            w_state_nxt = FILL;
            w_wcnt_nxt  = '0;
            w_wbank_nxt = 1'b0;
        end else if (i_ce) begin
            w_we = 1'b1;
            if (i_sync && (r_wcnt != '0)) begin
                // Restart the frame in the same half; the previous complete
                // frame in the other half is left untouched.
                w_wword     = '0;
                w_wcnt_nxt  = c_WW'(1);
                w_state_nxt = FILL;
                w_err_nxt   = 1'b1;
            end else begin
                w_byp_en    = r_bypass;
                w_rd_en     = !r_bypass && (r_state == RUN);
                w_valid_nxt = r_bypass || (r_state == RUN);
                w_sync_nxt  = w_valid_nxt && (r_wcnt == '0);
                if (r_wcnt == w_last) begin
                    w_wcnt_nxt  = '0;
                    w_wbank_nxt = ~r_wbank;
                    w_state_nxt = RUN;
                end else begin
                    w_wcnt_nxt = r_wcnt + c_WW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= FILL;
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_wbank <= w_wbank_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lg      <= LW'(LGMAX);
            r_bypass  <= 1'b0;
            o_valid   <= 1'b0;
            o_sync    <= 1'b0;
            o_err     <= 1'b0;
            r_sel     <= 1'b0;
            r_use_byp <= 1'b0;
            r_byp_0   <= '0;
            r_byp_1   <= '0;
        end else begin
            o_valid <= w_valid_nxt;
            o_sync  <= w_sync_nxt;
            o_err   <= w_err_nxt;
            if (i_cfg_load) begin
                r_lg     <= w_lg_clamp;
                r_bypass <= i_bypass;
            end
            if (w_rd_en) begin
                r_sel     <= w_sel;
                r_use_byp <= 1'b0;
            end
            if (w_byp_en) begin
                r_byp_0   <= i_in_0;
                r_byp_1   <= i_in_1;
                r_use_byp <= 1'b1;
            end
        end
    end

    assign w_wdata[0] = i_in_0;
    assign w_wdata[1] = i_in_1;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        bitrev_lane_ram #(
            .LGMAX (LGMAX),
            .DW    (2*WIDTH)
        ) u_ram (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_we      (w_we),
            .i_waddr   (w_waddr),
            .i_wdata   (w_wdata[g]),
            .i_re      (w_rd_en),
            .i_raddr_a (w_raddr_a),
            .i_raddr_b (w_raddr_b),
            .o_rdata_a (w_rdata_a[g]),
            .o_rdata_b (w_rdata_b[g])
        );
    end

    // Read registers and bypass registers only load on output beats, so the
    // selected source holds its value while o_valid is low.
    assign o_out_0 = r_use_byp ? r_byp_0 : (r_sel ? w_rdata_a[1] : w_rdata_a[0]);
    assign o_out_1 = r_use_byp ? r_byp_1 : (r_sel ? w_rdata_b[1] : w_rdata_b[0]);

endmodule
`default_nettype wire

// File: tb/tb_bitreverse_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bitreverse_cfg
//  Purpose  : Self-checking bench for bitreverse_cfg. A natural-order frame
//             model pushes expected pairs into a queue as beats are issued;
//             a monitor pops and compares whenever o_valid is seen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bitreverse_cfg;

    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_ce, i_sync, i_cfg_load, i_bypass;
    logic [31:0]   i_in_0, i_in_1;
    logic [LW-1:0] i_lgsize;
    logic [31:0]   o_out_0, o_out_1;
    logic          o_valid, o_sync, o_err;

    always #5 clk = ~clk;

    bitreverse_cfg #(.LGMAX(12), .LGMIN(3), .WIDTH(16)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_ce       (i_ce),
        .i_sync     (i_sync),
        .i_in_0     (i_in_0),
        .i_in_1     (i_in_1),
        .i_cfg_load (i_cfg_load),
        .i_lgsize   (i_lgsize),
        .i_bypass   (i_bypass),
        .o_out_0    (o_out_0),
        .o_out_1    (o_out_1),
        .o_valid    (o_valid),
        .o_sync     (o_sync),
        .o_err      (o_err)
    );

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        sync;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    logic [31:0] cur [4096];
    logic [31:0] prev[4096];
    int          m_L = 12;
    int          m_wcnt = 0;
    bit          m_fill = 1'b1;
    bit          m_byp = 1'b0;
    int          m_exp_err = 0;
    int          got_err = 0;

    // Reverse the low L bits of v by plain arithmetic.
    function automatic int rev(int v, int L);
        int r = 0;
        for (int i = 0; i < L; i++) r = r * 2 + ((v >> i) & 1);
        return r;
    endfunction

    task automatic check(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: store by natural index, replay previous frame in order.
    task automatic model_beat(bit sync, logic [31:0] d0, logic [31:0] d1);
        int n2;
        exp_t e;
        n2 = (1 << m_L) / 2;
        if (sync && m_wcnt != 0) begin
            cur[rev(0, m_L)] = d0;
            cur[rev(1, m_L)] = d1;
            m_wcnt = 1;
            m_fill = 1'b1;
            m_exp_err++;
            return;
        end
        if (m_byp) begin
            e.d0 = d0; e.d1 = d1; e.sync = (m_wcnt == 0);
            q.push_back(e);
        end else if (!m_fill) begin
            e.d0 = prev[2*m_wcnt]; e.d1 = prev[2*m_wcnt+1]; e.sync = (m_wcnt == 0);
            q.push_back(e);
        end
        cur[rev(2*m_wcnt, m_L)]   = d0;
        cur[rev(2*m_wcnt+1, m_L)] = d1;
        m_wcnt++;
        if (m_wcnt == n2) begin
            m_wcnt = 0;
            m_fill = 1'b0;
            prev   = cur;
        end
    endtask

    task automatic beat(bit ce, bit sync, logic [31:0] d0, logic [31:0] d1);
        @(negedge clk);
        i_ce = ce; i_sync = sync; i_in_0 = d0; i_in_1 = d1; i_cfg_load = 1'b0;
        if (ce) model_beat(sync, d0, d1);
    endtask

    task automatic run_beats(int n);
        for (int k = 0; k < n; k++) beat(1'b1, (m_wcnt == 0), $urandom, $urandom);
    endtask

    task automatic cfg(int lg, bit byp, bit ce_same);
        @(negedge clk);
        i_cfg_load = 1'b1; i_lgsize = LW'(lg); i_bypass = byp;
        i_ce = ce_same; i_sync = 1'b0; i_in_0 = $urandom; i_in_1 = $urandom;
        m_L    = (lg < 3) ? 3 : (lg > 12) ? 12 : lg;
        m_byp  = byp;
        m_wcnt = 0;
        m_fill = 1'b1;
        @(negedge clk);
        i_cfg_load = 1'b0; i_ce = 1'b0;
        check("cfg_valid_cleared", 96'(o_valid), 96'(0));
    endtask

    // Monitor: scoreboard pop on every output beat.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (o_err) got_err++;
        if (o_sync && !o_valid) begin
            checks++; errors++;
            $display("FAIL sync_without_valid: got o_sync=1 o_valid=0 required o_sync=0");
        end
        if (o_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h %h required no output", o_out_0, o_out_1);
            end else begin
                e = q.pop_front();
                check("out_pair", {o_out_0, o_out_1, 31'd0, o_sync},
                                  {e.d0, e.d1, 31'd0, e.sync});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fa[8];
        int beats;
        bit ce;
        rst_n = 1'b0; i_ce = 1'b0; i_sync = 1'b0; i_cfg_load = 1'b0;
        i_bypass = 1'b0; i_lgsize = '0; i_in_0 = '0; i_in_1 = '0;
        #12;
        check("reset_out0",  96'(o_out_0), 96'(0));
        check("reset_out1",  96'(o_out_1), 96'(0));
        check("reset_flags", 96'({o_valid, o_sync, o_err}), 96'(0));
        @(negedge clk); rst_n = 1'b1;

        // Directed L=3 frame A then B; frame C flushes B.
        cfg(3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) fa[i] = 32'hA000_0000 + 32'(i);
        for (int t = 0; t < 4; t++) begin
            beat(1'b1, (t == 0), fa[rev(2*t, 3)], fa[rev(2*t+1, 3)]);
            check("no_output_in_fill", 96'(o_valid), 96'(0));
        end
        for (int t = 0; t < 4; t++)
            beat(1'b1, (t == 0), 32'hB000_0000 + 32'(rev(2*t, 3)), 32'hB000_0000 + 32'(rev(2*t+1, 3)));
        run_beats(4);

        // L=12, random i_ce, three frames; stray i_sync on idle cycles.
        cfg(12, 1'b0, 1'b0);
        beats = 0;
        while (beats < 3*2048) begin
            ce = 1'($urandom_range(0, 1));
            beat(ce, ce ? (m_wcnt == 0) : 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (ce) beats++;
        end

        // Sync realignment at wcnt = 2.
        cfg(3, 1'b0, 1'b0);
        run_beats(6);
        beat(1'b1, 1'b1, $urandom, $urandom);
        run_beats(12);

        // Resize L=4 -> requested 2 (clamped to 3), with a dropped same-cycle beat.
        cfg(4, 1'b0, 1'b0);
        run_beats(12);
        cfg(2, 1'b0, 1'b1);
        run_beats(16);

        // Requested 15 clamps to 12.
        cfg(15, 1'b0, 1'b0);
        run_beats(2*2048 + 4);

        // Bypass.
        cfg(3, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 32'h11, 32'h22);
        run_beats(6);

        // Asynchronous reset mid-RUN.
        cfg(3, 1'b0, 1'b0);
        run_beats(6);
        @(negedge clk);
        i_ce = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out0",  96'(o_out_0), 96'(0));
        check("async_reset_out1",  96'(o_out_1), 96'(0));
        check("async_reset_flags", 96'({o_valid, o_sync, o_err}), 96'(0));
        q.delete();
        m_L = 12; m_byp = 1'b0; m_wcnt = 0; m_fill = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        run_beats(2048 + 8);

        for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, '0, '0);
        check("queue_drained", 96'(q.size()), 96'(0));
        check("err_pulses", 96'(got_err), 96'(m_exp_err));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
